regfile_dump_reader: RTL and testbench
======================================

Name: regfile_dump_reader

Overview:
- Initiator that sweeps a register-file memory through its synchronous read port and streams every word out over a valid/ready interface.
- Used by the debug/trace path to dump CPU register state without stalling the core.
- Snoops the memory's write port so every streamed word matches the register's current contents at handshake time, even while the core keeps writing.

Parameters:
SIZE, 32, number of memory words; address width AW = $clog2(SIZE)

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  reset, asynchronous, active-high
start  input  1  one-cycle request to begin a dump; ignored while busy=1
abort  input  1  synchronous flush of an active dump
busy  output  1  high from the edge that accepts start until return to IDLE
done  output  1  one-cycle pulse after the last word handshakes
rd_addr  output  AW  drives the memory read-port address
rd_data  input  32  memory read-port data; valid the cycle after rd_addr was sampled
wr_en  input  1  snoop of the memory write enable
wr_addr  input  AW  snoop of the memory write address
wr_data  input  32  snoop of the memory write data
out_valid  output  1  stream word valid
out_ready  input  1  downstream accept
out_data  output  32  register value
out_addr  output  AW  index of out_data
out_last  output  1  high with out_valid when out_addr == SIZE-1

Behaviour:
- Reset values: busy=0, done=0, out_valid=0, out_last=0, out_data=0, out_addr=0, rd_addr=0. FIFO is empty, no reads are in flight, and the block is in IDLE.
- States and transitions:
  - IDLE: waits for start; start=1 moves to RUN.
  - RUN: issues reads, one per cycle at most. After address SIZE-1 has been issued, moves to DRAIN.
  - DRAIN: waits for the last word's handshake, then moves to IDLE.
- done pulses in the cycle after that final handshake.
- Issue pointer: starts at 0 and increments by 1 per issued read. rd_addr = issue pointer while in RUN, and holds its last value otherwise.
- Memory read latency is 1 cycle. A read returns into a 2-entry output FIFO.
- Issue rule: issue only when (FIFO entries + reads in flight - pop this cycle) < 2. This guarantees no overflow. With out_ready held high, throughput is 1 word/cycle.
- Pop occurs when out_valid && out_ready. out_data, out_addr and out_last come from the FIFO head. out_valid = FIFO not empty.
- First-word latency: start is sampled at edge E0. Address 0 is presented after E0. out_valid rises after E2.
- Coherency invariant: while out_valid=1, out_data equals mem[out_addr] including every write committed at earlier edges. Required merges:
  - A write in the same cycle that rd_addr is sampled, to that address, must replace the returned data.
  - A write in the cycle rd_data is returning, to that address, must replace the data at capture.
  - A write to an address held in a FIFO entry updates that entry in place.
  - A write to the current head during the handshake cycle does not change the handshaken word.
- abort while busy: the next edge clears the FIFO, discards in-flight reads, drops out_valid and moves to IDLE. done is not pulsed. abort in IDLE has no effect.
- start and abort both high in IDLE: abort wins and no dump starts.
- start while busy is ignored and not queued.
- RST mid-dump: all state returns immediately to reset values. done is not pulsed.
- SIZE=1: a single word is streamed with out_last=1.
- The issue pointer never wraps. Exactly SIZE words are produced per dump, in ascending address order, with no gaps or duplicates.

Test Plan:
1. Memory preloaded mem[i]=i*0x11111111 mod 2^32, out_ready=1, pulse start -> 32 consecutive words addr 0..31; out_valid first high 2 edges after start; out_last only on addr 31; done pulses once.
2. out_ready toggling 1,0,0,1 repeating -> same 32 words in order; no loss or duplication; rd_addr never runs more than 2 words ahead of the pop count.
3. While streaming, write 0xDEADBEEF to addr 5 in the cycle rd_addr=5 is presented, and 0xCAFEF00D to addr 6 while word 6 sits in the FIFO with out_ready=0 -> out_data 0xDEADBEEF @5, 0xCAFEF00D @6.
4. abort asserted after word 10 handshakes -> out_valid low the next cycle, no done, busy=0; a following start dumps 0..31 from scratch.
5. RST asserted mid-dump asynchronously (between edges) -> busy, out_valid and done go low without waiting for CLK; a subsequent start behaves as in scenario 1.
6. start pulsed again while busy, and start+abort together in IDLE -> both ignored; exactly one dump of 32 words, one done pulse.

Source files
------------

// File: rtl/regfile_dump_reader_if.sv
// Output stream bundle of the register-file dump reader.
//   out_valid : word present at the stream head
//   out_ready : downstream accepts the head word this cycle
//   out_data  : register value
//   out_addr  : register index of out_data
//   out_last  : head word is the final register of the dump
// master = the dump reader (producer), slave = the downstream consumer.
interface regfile_dump_reader_if #(
  parameter int AW = 5
);
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_data;
  logic [AW-1:0] out_addr;
  logic          out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_addr,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_addr,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/regfile_dump_reader.sv
// Register-file dump reader: sweeps a memory through its synchronous read
// port (1-cycle latency) and streams every word, in ascending address order,
// through a 2-entry output FIFO. The memory write port is snooped so that
// every word leaving the block reflects the register's current contents.
// Ports:
//   CLK, RST            : clock, asynchronous active-high reset
//   start, abort        : begin a dump / flush an active dump
//   busy, done          : dump in progress / one-cycle completion pulse
//   rd_addr, rd_data    : memory read port (address out, data back next cycle)
//   wr_en/addr/data     : snoop of the memory write port
//   out_if (master)     : valid/ready output stream
module regfile_dump_reader #(
  parameter int SIZE = 32,
  parameter int AW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [AW-1:0]         rd_addr,
  input  logic [31:0]           rd_data,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [31:0]           wr_data,
  regfile_dump_reader_if.master out_if
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_ADDR = AW'(SIZE - 1);
  localparam logic [AW:0]   LAST_PTR  = (AW + 1)'(SIZE - 1);

  state_t                 state_r, state_nxt_s;
  logic                   busy_r, done_r, done_nxt_s;
  logic [AW-1:0]          rd_addr_r;
  logic [AW:0]            issue_ptr_r;
  logic                   inflight_r;
  logic [AW-1:0]          inflight_addr_r;
  logic                   inflight_fwd_r;
  logic [31:0]            inflight_fwd_data_r;
  logic [1:0]             count_r, count_nxt_s;
  logic [1:0][31:0]       slot_data_r, slot_data_nxt_s, merged_data_s;
  logic [1:0][AW-1:0]     slot_addr_r, slot_addr_nxt_s;
  logic                   pop_s, issue_s, flush_s, head_last_s;
  logic [2:0]             occ_s;
  logic [31:0]            cap_data_s;

  assign flush_s     = abort && (state_r != S_IDLE);
  assign pop_s       = (count_r != 2'd0) && out_if.out_ready;
  assign head_last_s = (count_r != 2'd0) && (slot_addr_r[0] == LAST_ADDR);
  // Occupancy after this cycle's pop; keeping it below 2 means the word
  // returning next cycle always has a free FIFO slot.
  assign occ_s       = {1'b0, count_r} + {2'b00, inflight_r} - {2'b00, pop_s};
  assign issue_s     = (state_r == S_RUN) && !abort && (occ_s < 3'd2);

  // Next-state and done-pulse decode.
  always_comb begin
    state_nxt_s = state_r;
    done_nxt_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start && !abort) state_nxt_s = S_RUN;
        else                 state_nxt_s = S_IDLE;
      end
      S_RUN: begin
        if (abort)                                   state_nxt_s = S_IDLE;
        else if (issue_s && issue_ptr_r == LAST_PTR) state_nxt_s = S_DRAIN;
        else                                         state_nxt_s = S_RUN;
      end
      S_DRAIN: begin
        if (abort) begin
          state_nxt_s = S_IDLE;
        end else if (pop_s && head_last_s) begin
          state_nxt_s = S_IDLE;
          done_nxt_s  = 1'b1;
        end else begin
          state_nxt_s = S_DRAIN;
        end
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // FIFO next contents: snoop merge, then pop (shift), then push of the return.
  always_comb begin
    // A write during the return cycle beats one captured at the issue edge,
    // which in turn beats the (possibly stale) memory output.
    if (wr_en && (wr_addr == inflight_addr_r)) cap_data_s = wr_data;
    else if (inflight_fwd_r)                    cap_data_s = inflight_fwd_data_r;
    else                                        cap_data_s = rd_data;

    for (int i = 0; i < 2; i++) begin
      if (wr_en && (count_r > 2'(i)) && (wr_addr == slot_addr_r[i]))
        merged_data_s[i] = wr_data;
      else
        merged_data_s[i] = slot_data_r[i];
    end

    slot_data_nxt_s = merged_data_s;
    slot_addr_nxt_s = slot_addr_r;
    count_nxt_s     = count_r;

    if (pop_s) begin
      slot_data_nxt_s[0] = merged_data_s[1];
      slot_addr_nxt_s[0] = slot_addr_r[1];
      count_nxt_s        = count_r - 2'd1;
    end else begin
      count_nxt_s        = count_r;
    end

    if (inflight_r) begin
      if (count_nxt_s == 2'd0) begin
        slot_data_nxt_s[0] = cap_data_s;
        slot_addr_nxt_s[0] = inflight_addr_r;
      end else begin
        slot_data_nxt_s[1] = cap_data_s;
        slot_addr_nxt_s[1] = inflight_addr_r;
      end
      count_nxt_s = count_nxt_s + 2'd1;
    end else begin
      count_nxt_s = count_nxt_s;
    end

    if (flush_s) count_nxt_s = 2'd0;
    else         count_nxt_s = count_nxt_s;
  end

  // Control state register plus registered busy/done outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != S_IDLE);
      done_r  <= done_nxt_s;
    end
  end

  // Read issue pointer, in-flight tracking and FIFO storage.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_addr_r           <= '0;
      issue_ptr_r         <= '0;
      inflight_r          <= 1'b0;
      inflight_addr_r     <= '0;
      inflight_fwd_r      <= 1'b0;
      inflight_fwd_data_r <= 32'd0;
      count_r             <= 2'd0;
      slot_data_r         <= '0;
      slot_addr_r         <= '0;
    end else begin
      count_r             <= count_nxt_s;
      slot_data_r         <= slot_data_nxt_s;
      slot_addr_r         <= slot_addr_nxt_s;
      // issue_s is never set while flushing, so discarding in-flight reads
      // on abort falls out of this assignment.
      inflight_r          <= issue_s;
      inflight_addr_r     <= rd_addr_r;
      // A write committed at the same edge the memory samples rd_addr may
      // not be visible in rd_data, so remember it for the return cycle.
      inflight_fwd_r      <= wr_en && (wr_addr == rd_addr_r);
      inflight_fwd_data_r <= wr_data;
      if (state_r == S_IDLE && start && !abort) begin
        issue_ptr_r <= '0;
        rd_addr_r   <= '0;
      end else if (issue_s) begin
        issue_ptr_r <= issue_ptr_r + (AW + 1)'(1);
        // Hold the last address once the sweep is complete.
        if (issue_ptr_r != LAST_PTR) rd_addr_r <= rd_addr_r + AW'(1);
        else                         rd_addr_r <= rd_addr_r;
      end else begin
        issue_ptr_r <= issue_ptr_r;
        rd_addr_r   <= rd_addr_r;
      end
    end
  end

  assign busy             = busy_r;
  assign done             = done_r;
  assign rd_addr          = rd_addr_r;
  assign out_if.out_valid = (count_r != 2'd0);
  assign out_if.out_data  = slot_data_r[0];
  assign out_if.out_addr  = slot_addr_r[0];
  assign out_if.out_last  = head_last_s;

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;
  localparam int SIZE = 32;
  localparam int AW   = 5;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0, abort = 1'b0;
  logic          busy, done;
  logic [AW-1:0] rd_addr;
  logic [31:0]   rd_data;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [31:0]   wr_data = 32'd0;
  logic          preload_en = 1'b0;

  regfile_dump_reader_if #(.AW(AW)) bus ();

  regfile_dump_reader #(.SIZE(SIZE)) dut (
    .CLK(CLK), .RST(RST), .start(start), .abort(abort), .busy(busy), .done(done),
    .rd_addr(rd_addr), .rd_data(rd_data), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .out_if(bus)
  );

  // Single-register instance for the SIZE=1 boundary.
  logic start1 = 1'b0;
  logic busy1, done1;
  logic [0:0] rd_addr1;
  regfile_dump_reader_if #(.AW(1)) bus1 ();
  regfile_dump_reader #(.SIZE(1)) dut1 (
    .CLK(CLK), .RST(RST), .start(start1), .abort(1'b0), .busy(busy1), .done(done1),
    .rd_addr(rd_addr1), .rd_data(32'hA5A50001), .wr_en(1'b0), .wr_addr(1'b0),
    .wr_data(32'd0), .out_if(bus1)
  );

  always #5 CLK = ~CLK;

  // Memory model: write port plus read-old-data synchronous read port.
  logic [31:0] mem [SIZE];
  always @(posedge CLK) begin
    if (preload_en) begin
      for (int i = 0; i < SIZE; i++) mem[i] <= i * 32'h11111111;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    rd_data <= mem[rd_addr];
  end

  int tests = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic preload();
    @(negedge CLK); preload_en = 1'b1;
    @(negedge CLK); preload_en = 1'b0;
  endtask

  typedef struct {
    int ready_mode;   // 0 always ready, 1 pattern 1001, 2 random, 3 directed merges
    int wr_pct;
    int abort_after;  // words handshaken before abort, -1 for none
    bit restart;      // pulse start again mid-dump
    int exp_words;
    int exp_dones;
  } vec_t;

  // One dump: checks ordering, last flag, coherency and done timing each cycle.
  task automatic run_dump(input vec_t v, output int words, output int dones);
    int cyc = 0;
    bit last_hs = 1'b0, aborted = 1'b0, w5 = 1'b0, w6 = 1'b0, hs;
    int stall = 0;
    logic [31:0] d5 = 32'd0, d6 = 32'd0;
    words = 0; dones = 0;
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    while (cyc < 2000) begin
      start = 1'b0; abort = 1'b0; wr_en = 1'b0;
      chk("done_timing", done, last_hs);
      if (done) begin
        dones++;
        chk("busy_at_done", busy, 1'b0);
      end
      if (aborted) begin
        chk("abort_busy", busy, 1'b0);
        chk("abort_valid", bus.out_valid, 1'b0);
        break;
      end
      if (done) break;
      case (v.ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
        2: bus.out_ready = ($urandom_range(0, 3) != 0);
        default: begin
          bus.out_ready = 1'b1;
          if (bus.out_valid && bus.out_addr == 5'd5 && stall < 2) begin
            bus.out_ready = 1'b0;
            stall++;
          end
        end
      endcase
      if (v.ready_mode == 3) begin
        if (busy && rd_addr == 5'd5 && !w5) begin
          wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; w5 = 1'b1;
        end else if (stall == 2 && !w6) begin
          wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hCAFEF00D; w6 = 1'b1;
        end
      end else if ($urandom_range(0, 99) < v.wr_pct) begin
        wr_en = 1'b1; wr_addr = AW'($urandom_range(0, SIZE - 1)); wr_data = $urandom;
      end
      if (v.restart && cyc == 10) start = 1'b1;
      if (v.abort_after >= 0 && words == v.abort_after) begin
        abort = 1'b1; bus.out_ready = 1'b0; aborted = 1'b1;
      end
      if (busy) chk("rd_ahead", (int'(rd_addr) <= words + 2), 1'b1);
      if (bus.out_valid) chk("coherent", bus.out_data, mem[bus.out_addr]);
      hs = bus.out_valid && bus.out_ready;
      if (hs) begin
        chk("addr_order", bus.out_addr, words);
        chk("last_flag", bus.out_last, (words == SIZE - 1));
        if (v.wr_pct == 0 && v.ready_mode != 3)
          chk("preload_data", bus.out_data, words * 32'h11111111);
        if (words == 5) d5 = bus.out_data;
        if (words == 6) d6 = bus.out_data;
        last_hs = (words == SIZE - 1);
        words++;
      end else begin
        last_hs = 1'b0;
      end
      @(negedge CLK);
      cyc++;
    end
    if (cyc >= 2000) chk("dump_timeout", 32'd1, 32'd0);
    if (v.ready_mode == 3) begin
      chk("merge_issue_5", d5, 32'hDEADBEEF);
      chk("merge_fifo_6", d6, 32'hCAFEF00D);
    end
    start = 1'b0; abort = 1'b0; wr_en = 1'b0; bus.out_ready = 1'b1;
  endtask

  vec_t vecs[9];
  int words, dones, k;

  initial begin
    bus.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    vecs[0] = '{0,  0, -1, 1'b0, 32, 1};
    vecs[1] = '{1,  0, -1, 1'b0, 32, 1};
    vecs[2] = '{3,  0, -1, 1'b0, 32, 1};
    vecs[3] = '{0,  0, 11, 1'b0, 11, 0};
    vecs[4] = '{0,  0, -1, 1'b0, 32, 1};
    vecs[5] = '{0,  0, -1, 1'b1, 32, 1};
    vecs[6] = '{2, 30, -1, 1'b0, 32, 1};
    vecs[7] = '{2, 50, -1, 1'b0, 32, 1};
    vecs[8] = '{1, 40, -1, 1'b0, 32, 1};

    // Reset values.
    #12;
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_last", bus.out_last, 1'b0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_addr", bus.out_addr, 5'd0);
    chk("rst_rd_addr", rd_addr, 5'd0);
    @(negedge CLK); RST = 1'b0;
    preload();

    // First-word latency: start sampled at E0, valid after E2.
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    chk("lat_busy_e0", busy, 1'b1);
    chk("lat_rdaddr_e0", rd_addr, 5'd0);
    chk("lat_valid_e0", bus.out_valid, 1'b0);
    @(negedge CLK);
    chk("lat_valid_e1", bus.out_valid, 1'b0);
    @(negedge CLK);
    chk("lat_valid_e2", bus.out_valid, 1'b1);
    chk("lat_addr_e2", bus.out_addr, 5'd0);
    k = 0;
    while (!done && k < 100) begin @(negedge CLK); k++; end
    chk("lat_done_seen", done, 1'b1);

    // start and abort together in IDLE: nothing happens.
    @(negedge CLK); start = 1'b1; abort = 1'b1;
    @(negedge CLK); start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("idle_startabort_busy", busy, 1'b0);
      chk("idle_startabort_valid", bus.out_valid, 1'b0);
      @(negedge CLK);
    end

    // Table-driven dumps.
    for (int i = 0; i < 9; i++) begin
      preload();
      run_dump(vecs[i], words, dones);
      chk("vec_words", words, vecs[i].exp_words);
      chk("vec_dones", dones, vecs[i].exp_dones);
      repeat (3) @(negedge CLK);
      chk("vec_idle_busy", busy, 1'b0);
    end

    // Asynchronous reset mid-dump.
    preload();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
    repeat (15) @(negedge CLK);
    chk("pre_rst_busy", busy, 1'b1);
    @(posedge CLK); #2 RST = 1'b1;
    #1;
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_valid", bus.out_valid, 1'b0);
    chk("async_rst_done", done, 1'b0);
    @(negedge CLK); RST = 1'b0;
    preload();
    run_dump(vecs[0], words, dones);
    chk("post_rst_words", words, 32);
    chk("post_rst_dones", dones, 1);

    // SIZE=1 instance: a single word flagged last.
    @(negedge CLK); start1 = 1'b1;
    @(negedge CLK); start1 = 1'b0;
    k = 0;
    while (!bus1.out_valid && k < 20) begin @(negedge CLK); k++; end
    chk("s1_valid", bus1.out_valid, 1'b1);
    chk("s1_last", bus1.out_last, 1'b1);
    chk("s1_addr", bus1.out_addr, 1'b0);
    chk("s1_data", bus1.out_data, 32'hA5A50001);
    @(negedge CLK);
    chk("s1_done", done1, 1'b1);
    chk("s1_valid_after", bus1.out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
